// File: rtl/stream_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one narrow stream sink between N_REQ requesters.
// Optional per-grant beat limit with forced last and trunc_o pulse: define STREAM_ARB_BEAT_LIMIT_EN.
module stream_packet_arbiter #(
    parameter int T_DATA_WIDTH = 1,
    parameter int N_REQ        = 2,
    parameter int ID_WIDTH     = $clog2(N_REQ),
    parameter int MAX_BEATS    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [N_REQ],
    input  logic [N_REQ-1:0]        s_last_i,
    input  logic [N_REQ-1:0]        s_valid_i,
    output logic [N_REQ-1:0]        s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [ID_WIDTH-1:0]     m_id_o,
    output logic                    busy_o
`ifdef STREAM_ARB_BEAT_LIMIT_EN
    ,
    output logic                    trunc_o
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [ID_WIDTH:0]   NREQ_W  = (ID_WIDTH+1)'(N_REQ);
    localparam logic [ID_WIDTH-1:0] PTR_RST = ID_WIDTH'(N_REQ-1);

    if (N_REQ < 2 || N_REQ > 16 || MAX_BEATS < 1) begin : g_param_check
        $error("stream_packet_arbiter: N_REQ must be 2..16 and MAX_BEATS >= 1");
    end

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                started_q, started_d;
    logic [ID_WIDTH:0]   pick_idle, pick_ho;
    logic                g_valid, g_last, hs, at_limit;

    // Returns {found, index} of the first request searching upward from base+1 with wrap.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [ID_WIDTH-1:0] base,
                                                  input logic [N_REQ-1:0]    req);
        logic [ID_WIDTH:0]   idx;
        logic                found;
        logic [ID_WIDTH-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = {1'b0, base} + (ID_WIDTH+1)'(i);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (req[idx[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_WIDTH-1:0];
            end
        end
        return {found, win};
    endfunction

    assign pick_idle = rr_pick(ptr_q, s_valid_i);
    assign pick_ho   = rr_pick(grant_q, s_valid_i);
    assign g_valid   = s_valid_i[grant_q];
    assign g_last    = s_last_i[grant_q] | at_limit;
    assign hs        = (state_q == GRANT) && g_valid && m_ready_i;
    assign m_id_o    = grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_RST;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        started_d = started_q;
        s_ready_o = '0;
        m_data_o  = '0;
        m_last_o  = 1'b0;
        m_valid_o = 1'b0;
        busy_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_idle[ID_WIDTH]) begin
                    grant_d   = pick_idle[ID_WIDTH-1:0];
                    started_d = 1'b0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                busy_o             = 1'b1;
                m_valid_o          = g_valid;
                m_last_o           = g_last;
                m_data_o           = s_data_i[grant_q];
                s_ready_o[grant_q] = m_ready_i;
                if (hs) begin
                    if (g_last) begin
                        ptr_d     = grant_q;
                        started_d = 1'b0;
                        if (pick_ho[ID_WIDTH]) grant_d = pick_ho[ID_WIDTH-1:0];
                        else                   state_d = IDLE;
                    end else begin
                        started_d = 1'b1;
                    end
                end else if (!g_valid && !started_q) begin
                    // A finisher re-granted with nothing queued releases before its packet starts,
                    // so an idle requester cannot lock out the others.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STREAM_ARB_BEAT_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BEATS+1);

    logic [CNT_W-1:0] cnt_q;
    logic             trunc_q;

    assign at_limit = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_BEATS-1));
    assign trunc_o  = trunc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= hs && at_limit && !s_last_i[grant_q];
            if (hs && !g_last)               cnt_q <= cnt_q + 1'b1;
            else if (hs || state_q == IDLE)  cnt_q <= '0;
        end
    end
`else
    assign at_limit = 1'b0;
`endif

endmodule
